// File: rtl/rob_reg_release_if.sv
// rob_reg_release_if
//   Bundles the rename/writeback/flush inputs and the commit/restore/free
//   outputs of the reorder buffer.
//   master : rename / execute / free-list side (drives alloc, wb, flush)
//   slave  : the ROB (drives ready, index, commit, restore, free, status)
interface rob_reg_release_if #(
    parameter int ROB_IDX_BITS  = 4,
    parameter int PHYS_REG_BITS = 6,
    parameter int ARCH_REG_BITS = 5
);
    logic                     alloc_en;
    logic                     alloc_has_dest;
    logic [ARCH_REG_BITS-1:0] alloc_arch_rd;
    logic [PHYS_REG_BITS-1:0] alloc_new_phys;
    logic [PHYS_REG_BITS-1:0] alloc_old_phys;
    logic                     alloc_ready;
    logic [ROB_IDX_BITS-1:0]  alloc_idx;
    logic                     wb_en;
    logic [ROB_IDX_BITS-1:0]  wb_idx;
    logic                     flush;
    logic                     commit_en;
    logic [ARCH_REG_BITS-1:0] commit_arch_rd;
    logic [PHYS_REG_BITS-1:0] commit_phys;
    logic                     restore_en;
    logic [ARCH_REG_BITS-1:0] restore_arch_rd;
    logic [PHYS_REG_BITS-1:0] restore_phys;
    logic                     free_en;
    logic [PHYS_REG_BITS-1:0] free_reg;
    logic                     walking;
    logic [ROB_IDX_BITS:0]    count;

    modport master (
        output alloc_en, alloc_has_dest, alloc_arch_rd, alloc_new_phys, alloc_old_phys,
        output wb_en, wb_idx, flush,
        input  alloc_ready, alloc_idx,
        input  commit_en, commit_arch_rd, commit_phys,
        input  restore_en, restore_arch_rd, restore_phys,
        input  free_en, free_reg, walking, count
    );

    modport slave (
        input  alloc_en, alloc_has_dest, alloc_arch_rd, alloc_new_phys, alloc_old_phys,
        input  wb_en, wb_idx, flush,
        output alloc_ready, alloc_idx,
        output commit_en, commit_arch_rd, commit_phys,
        output restore_en, restore_arch_rd, restore_phys,
        output free_en, free_reg, walking, count
    );
endinterface

// File: rtl/rob_reg_release.sv
// rob_reg_release
//   In-order reorder buffer owning the physical-register free port.
//   Rename pushes {arch rd, new phys, old phys}; writeback marks entries done;
//   in-order commit frees old phys. A flush starts a youngest-first walk that
//   frees each squashed new phys and hands {arch rd, old phys} back to the RAT.
// Ports
//   clk   : clock, all state on rising edge
//   rst_n : asynchronous active-low reset
//   bus   : rob_reg_release_if.slave (alloc / wb / flush in; commit, restore,
//           free, walking, count out)
module rob_reg_release #(
    parameter int ROB_DEPTH     = 16,
    parameter int ROB_IDX_BITS  = 4,
    parameter int PHYS_REG_BITS = 6,
    parameter int ARCH_REG_BITS = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    rob_reg_release_if.slave  bus
);
    typedef enum logic {RUN, WALK} state_t;

    typedef struct packed {
        logic                     has_dest;
        logic [ARCH_REG_BITS-1:0] arch_rd;
        logic [PHYS_REG_BITS-1:0] new_phys;
        logic [PHYS_REG_BITS-1:0] old_phys;
    } rob_ent_t;

    localparam logic [ROB_IDX_BITS:0] DEPTH_C = (ROB_IDX_BITS+1)'(ROB_DEPTH);
    localparam logic [ROB_IDX_BITS:0] ONE_C   = (ROB_IDX_BITS+1)'(1);

    state_t                  state;
    logic [ROB_IDX_BITS:0]   head, tail, count;
    logic [ROB_DEPTH-1:0]    valid, done;
    rob_ent_t                ent [ROB_DEPTH];

    logic [ROB_IDX_BITS-1:0] head_idx, tail_idx, walk_idx;
    rob_ent_t                head_ent, walk_ent, alloc_ent;
    logic                    empty, full, run;
    logic                    do_commit, do_alloc, do_wb, do_walk;

    assign head_idx = head[ROB_IDX_BITS-1:0];
    assign tail_idx = tail[ROB_IDX_BITS-1:0];
    // Youngest live entry sits just below the tail.
    assign walk_idx = tail_idx - ROB_IDX_BITS'(1);
    assign head_ent = ent[head_idx];
    assign walk_ent = ent[walk_idx];

    assign empty = (count == '0);
    assign full  = (count == DEPTH_C);
    assign run   = (state == RUN);

    // A write to x0 is kept as "no destination" so nothing is ever freed for it.
    assign alloc_ent.has_dest = bus.alloc_has_dest && (bus.alloc_arch_rd != '0);
    assign alloc_ent.arch_rd  = bus.alloc_arch_rd;
    assign alloc_ent.new_phys = bus.alloc_new_phys;
    assign alloc_ent.old_phys = bus.alloc_old_phys;

    // done is only ever set on valid entries, so done alone qualifies the head.
    assign do_commit = run && !empty && done[head_idx] && !bus.flush;
    assign do_alloc  = run && !full && bus.alloc_en && !bus.flush;
    assign do_wb     = bus.wb_en && valid[bus.wb_idx];
    assign do_walk   = (state == WALK);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= RUN;
            head  <= '0;
            tail  <= '0;
            count <= '0;
            valid <= '0;
            done  <= '0;
        end else if (run) begin
            if (bus.flush) begin
                if (!empty) state <= WALK;
            end else begin
                if (do_wb) done[bus.wb_idx] <= 1'b1;
                if (do_commit) begin
                    valid[head_idx] <= 1'b0;
                    done[head_idx]  <= 1'b0;
                    head            <= head + ONE_C;
                end
                if (do_alloc) begin
                    valid[tail_idx] <= 1'b1;
                    done[tail_idx]  <= 1'b0;
                    tail            <= tail + ONE_C;
                end
                count <= count + (ROB_IDX_BITS+1)'(do_alloc)
                               - (ROB_IDX_BITS+1)'(do_commit);
            end
        end else begin
            // One squashed entry per cycle; inputs are ignored while walking.
            valid[walk_idx] <= 1'b0;
            done[walk_idx]  <= 1'b0;
            tail            <= tail - ONE_C;
            count           <= count - ONE_C;
            if (count == ONE_C) state <= RUN;
        end
    end

    // Payload needs no reset: valid gates every use of it.
    always_ff @(posedge clk) begin
        if (do_alloc) ent[tail_idx] <= alloc_ent;
    end

    always_comb begin
        bus.alloc_ready     = run && !full;
        bus.alloc_idx       = tail_idx;
        bus.walking         = do_walk;
        bus.count           = count;
        bus.commit_en       = do_commit;
        bus.commit_arch_rd  = '0;
        bus.commit_phys     = '0;
        bus.restore_en      = 1'b0;
        bus.restore_arch_rd = '0;
        bus.restore_phys    = '0;
        bus.free_en         = 1'b0;
        bus.free_reg        = '0;
        if (do_commit && head_ent.has_dest) begin
            bus.commit_arch_rd = head_ent.arch_rd;
            bus.commit_phys    = head_ent.new_phys;
            bus.free_en        = 1'b1;
            bus.free_reg       = head_ent.old_phys;
        end
        // Commit and walk never coincide (different states): one free per cycle.
        if (do_walk && walk_ent.has_dest) begin
            bus.restore_en      = 1'b1;
            bus.restore_arch_rd = walk_ent.arch_rd;
            bus.restore_phys    = walk_ent.old_phys;
            bus.free_en         = 1'b1;
            bus.free_reg        = walk_ent.new_phys;
        end
    end
endmodule

// File: tb/tb_rob_reg_release.sv
module tb_rob_reg_release;
    localparam int D = 16, IB = 4, PB = 6, AB = 5;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    rob_reg_release_if #(.ROB_IDX_BITS(IB), .PHYS_REG_BITS(PB), .ARCH_REG_BITS(AB)) bus();
    rob_reg_release #(.ROB_DEPTH(D), .ROB_IDX_BITS(IB), .PHYS_REG_BITS(PB), .ARCH_REG_BITS(AB))
        dut (.clk(clk), .rst_n(rst_n), .bus(bus.slave));

    int n_cmp = 0;
    int n_err = 0;

    // ---------------- stimulus helpers (no checking) ----------------
    task automatic set_in(input logic a, input logic hd, input logic [AB-1:0] rd,
                          input logic [PB-1:0] np, input logic [PB-1:0] op,
                          input logic wb, input logic [IB-1:0] wi, input logic fl);
        bus.alloc_en = a; bus.alloc_has_dest = hd; bus.alloc_arch_rd = rd;
        bus.alloc_new_phys = np; bus.alloc_old_phys = op;
        bus.wb_en = wb; bus.wb_idx = wi; bus.flush = fl;
    endtask

    task automatic idle();
        set_in(1'b0, 1'b0, '0, '0, '0, 1'b0, '0, 1'b0);
    endtask

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic do_reset();
        idle();
        rst_n = 1'b0;
        @(posedge clk); @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    // ---------------- behavioural reference model ----------------
    typedef struct {
        logic          hd;
        logic [AB-1:0] rd;
        logic [PB-1:0] np;
        logic [PB-1:0] op;
        logic          done;
        logic [IB-1:0] idx;
    } ment_t;

    ment_t         mq[$];
    logic [IB-1:0] m_tail;
    logic          m_walk;

    logic          e_ready, e_walk, e_cen, e_ren, e_fen;
    logic [IB-1:0] e_idx;
    logic [IB:0]   e_count;
    logic [AB-1:0] e_crd, e_rrd;
    logic [PB-1:0] e_cph, e_rph, e_freg;

    // Free-list / RAT bookkeeping for the tag scoreboard.
    logic [PB-1:0] rat[32];
    logic [PB-1:0] fl_q[$];
    logic          in_free[64];

    task automatic model_reset();
        mq.delete();
        m_tail = '0;
        m_walk = 1'b0;
        for (int i = 0; i < 32; i++) rat[i] = PB'(i);
        fl_q.delete();
        for (int i = 0; i < 64; i++) begin
            in_free[i] = (i >= 32);
            if (i >= 32) fl_q.push_back(PB'(i));
        end
    endtask

    task automatic model_predict(input logic fl);
        e_idx = m_tail; e_count = (IB+1)'(mq.size()); e_walk = m_walk;
        e_ready = 1'b0; e_cen = 1'b0; e_ren = 1'b0; e_fen = 1'b0;
        e_crd = '0; e_cph = '0; e_rrd = '0; e_rph = '0; e_freg = '0;
        if (m_walk) begin
            if (mq[mq.size()-1].hd) begin
                e_ren = 1'b1; e_rrd = mq[mq.size()-1].rd; e_rph = mq[mq.size()-1].op;
                e_fen = 1'b1; e_freg = mq[mq.size()-1].np;
            end
        end else begin
            e_ready = (mq.size() < D);
            if (mq.size() > 0 && mq[0].done && !fl) begin
                e_cen = 1'b1;
                if (mq[0].hd) begin
                    e_crd = mq[0].rd; e_cph = mq[0].np; e_fen = 1'b1; e_freg = mq[0].op;
                end
            end
        end
    endtask

    task automatic model_update(input logic a, input logic hd, input logic [AB-1:0] rd,
                                input logic [PB-1:0] np, input logic [PB-1:0] op,
                                input logic wb, input logic [IB-1:0] wi, input logic fl);
        ment_t e;
        if (m_walk) begin
            void'(mq.pop_back());
            m_tail = m_tail - 1'b1;
            if (mq.size() == 0) m_walk = 1'b0;
        end else if (fl) begin
            if (mq.size() > 0) m_walk = 1'b1;
        end else begin
            if (e_cen) void'(mq.pop_front());
            if (wb) foreach (mq[i]) if (mq[i].idx == wi) mq[i].done = 1'b1;
            if (a && e_ready) begin
                e.hd = hd && (rd != 0); e.rd = rd; e.np = np; e.op = op;
                e.done = 1'b0; e.idx = m_tail;
                mq.push_back(e);
                m_tail = m_tail + 1'b1;
            end
        end
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        do_reset();
        #3;
        n_cmp++; if (bus.count !== 5'd0) begin n_err++; $display("FAIL rst_count got %0d want 0", bus.count); end
        n_cmp++; if (bus.alloc_ready !== 1'b1) begin n_err++; $display("FAIL rst_alloc_ready got %b want 1", bus.alloc_ready); end
        n_cmp++; if (bus.alloc_idx !== 4'd0) begin n_err++; $display("FAIL rst_alloc_idx got %0d want 0", bus.alloc_idx); end
        n_cmp++; if ({bus.free_en, bus.commit_en, bus.restore_en, bus.walking} !== 4'b0)
            begin n_err++; $display("FAIL rst_enables got %b want 0000", {bus.free_en, bus.commit_en, bus.restore_en, bus.walking}); end
        n_cmp++; if ({bus.free_reg, bus.commit_phys, bus.restore_phys} !== 18'd0)
            begin n_err++; $display("FAIL rst_data got %h want 0", {bus.free_reg, bus.commit_phys, bus.restore_phys}); end
        tick();
    endtask

    task automatic test_commit();
        do_reset();
        set_in(1'b1, 1'b1, 5'd5, 6'd32, 6'd5, 1'b0, 4'd0, 1'b0); #3;
        n_cmp++; if ({bus.alloc_ready, bus.alloc_idx} !== 5'b1_0000) begin n_err++; $display("FAIL cm_alloc got %b want 10000", {bus.alloc_ready, bus.alloc_idx}); end
        tick();
        set_in(1'b0, 1'b0, 5'd0, 6'd0, 6'd0, 1'b1, 4'd0, 1'b0); #3;
        n_cmp++; if ({bus.count, bus.commit_en} !== {5'd1, 1'b0}) begin n_err++; $display("FAIL cm_wb_cycle got cnt=%0d cen=%b want cnt=1 cen=0", bus.count, bus.commit_en); end
        tick();
        idle(); #3;
        n_cmp++; if ({bus.commit_en, bus.commit_arch_rd, bus.commit_phys} !== {1'b1, 5'd5, 6'd32})
            begin n_err++; $display("FAIL cm_commit got en=%b rd=%0d ph=%0d want 1/5/32", bus.commit_en, bus.commit_arch_rd, bus.commit_phys); end
        n_cmp++; if ({bus.free_en, bus.free_reg, bus.count} !== {1'b1, 6'd5, 5'd1})
            begin n_err++; $display("FAIL cm_free got en=%b reg=%0d cnt=%0d want 1/5/1", bus.free_en, bus.free_reg, bus.count); end
        tick(); #3;
        n_cmp++; if ({bus.count, bus.commit_en, bus.alloc_idx} !== {5'd0, 1'b0, 4'd1})
            begin n_err++; $display("FAIL cm_after got cnt=%0d cen=%b idx=%0d want 0/0/1", bus.count, bus.commit_en, bus.alloc_idx); end
        tick();
    endtask

    task automatic test_x0();
        do_reset();
        set_in(1'b1, 1'b1, 5'd0, 6'd33, 6'd0, 1'b0, 4'd0, 1'b0); tick();
        set_in(1'b0, 1'b0, 5'd0, 6'd0, 6'd0, 1'b1, 4'd0, 1'b0); tick();
        idle(); #3;
        n_cmp++; if ({bus.commit_en, bus.free_en, bus.commit_arch_rd, bus.commit_phys} !== {1'b1, 1'b0, 5'd0, 6'd0})
            begin n_err++; $display("FAIL x0_commit got cen=%b fen=%b rd=%0d ph=%0d want 1/0/0/0", bus.commit_en, bus.free_en, bus.commit_arch_rd, bus.commit_phys); end
        tick();
    endtask

    task automatic test_full_ooo();
        do_reset();
        for (int i = 0; i < D; i++) begin
            set_in(1'b1, 1'b1, 5'(i + 1), 6'(32 + i), 6'(i + 1), 1'b0, 4'd0, 1'b0);
            tick();
        end
        set_in(1'b1, 1'b1, 5'd9, 6'd60, 6'd9, 1'b1, 4'd3, 1'b0); #3;
        n_cmp++; if ({bus.alloc_ready, bus.count, bus.alloc_idx} !== {1'b0, 5'd16, 4'd0})
            begin n_err++; $display("FAIL full_state got rdy=%b cnt=%0d idx=%0d want 0/16/0", bus.alloc_ready, bus.count, bus.alloc_idx); end
        tick();
        set_in(1'b0, 1'b0, 5'd0, 6'd0, 6'd0, 1'b1, 4'd0, 1'b0); #3;
        n_cmp++; if (bus.commit_en !== 1'b0) begin n_err++; $display("FAIL full_no_commit got %b want 0", bus.commit_en); end
        tick();
        for (int k = 0; k < 4; k++) begin
            if (k < 2) set_in(1'b1, 1'b1, 5'd9, 6'd60, 6'd9, 1'b1, 4'(k + 1), 1'b0);
            else idle();
            #3;
            n_cmp++; if ({bus.commit_en, bus.free_en, bus.free_reg, bus.commit_arch_rd} !== {1'b1, 1'b1, 6'(k + 1), 5'(k + 1)})
                begin n_err++; $display("FAIL ooo_commit%0d got cen=%b fen=%b reg=%0d rd=%0d want 1/1/%0d/%0d", k, bus.commit_en, bus.free_en, bus.free_reg, bus.commit_arch_rd, k + 1, k + 1); end
            if (k == 0) begin
                n_cmp++; if ({bus.alloc_ready, bus.count} !== {1'b0, 5'd16})
                    begin n_err++; $display("FAIL full_commit_rdy got rdy=%b cnt=%0d want 0/16", bus.alloc_ready, bus.count); end
            end
            tick();
        end
        #3;
        // The k=0 cycle allocated nothing (full), k=1 allocated one.
        n_cmp++; if ({bus.commit_en, bus.count} !== {1'b0, 5'd13})
            begin n_err++; $display("FAIL ooo_after got cen=%b cnt=%0d want 0/13", bus.commit_en, bus.count); end
        tick();
    endtask

    task automatic test_flush_walk();
        do_reset();
        set_in(1'b0, 1'b0, 5'd0, 6'd0, 6'd0, 1'b0, 4'd0, 1'b1); tick(); idle(); #3;
        n_cmp++; if ({bus.walking, bus.alloc_ready, bus.count} !== {1'b0, 1'b1, 5'd0})
            begin n_err++; $display("FAIL fl_empty got walk=%b rdy=%b cnt=%0d want 0/1/0", bus.walking, bus.alloc_ready, bus.count); end
        set_in(1'b1, 1'b1, 5'd1, 6'd40, 6'd1, 1'b0, 4'd0, 1'b0); tick();
        set_in(1'b1, 1'b0, 5'd7, 6'd50, 6'd9, 1'b0, 4'd0, 1'b0); tick();
        set_in(1'b1, 1'b1, 5'd2, 6'd41, 6'd2, 1'b0, 4'd0, 1'b0); tick();
        set_in(1'b1, 1'b1, 5'd3, 6'd42, 6'd3, 1'b0, 4'd0, 1'b1); #3;
        n_cmp++; if ({bus.commit_en, bus.walking, bus.count} !== {1'b0, 1'b0, 5'd3})
            begin n_err++; $display("FAIL fl_cycle got cen=%b walk=%b cnt=%0d want 0/0/3", bus.commit_en, bus.walking, bus.count); end
        tick();
        // Inputs during the walk must be ignored.
        set_in(1'b1, 1'b1, 5'd9, 6'd60, 6'd9, 1'b1, 4'd0, 1'b1); #3;
        n_cmp++; if ({bus.walking, bus.alloc_ready, bus.commit_en} !== 3'b100)
            begin n_err++; $display("FAIL walk1_state got %b want 100", {bus.walking, bus.alloc_ready, bus.commit_en}); end
        n_cmp++; if ({bus.restore_en, bus.restore_arch_rd, bus.restore_phys, bus.free_en, bus.free_reg} !== {1'b1, 5'd2, 6'd2, 1'b1, 6'd41})
            begin n_err++; $display("FAIL walk1_out got ren=%b rd=%0d ph=%0d fen=%b reg=%0d want 1/2/2/1/41", bus.restore_en, bus.restore_arch_rd, bus.restore_phys, bus.free_en, bus.free_reg); end
        tick(); #3;
        n_cmp++; if ({bus.restore_en, bus.free_en, bus.walking, bus.count} !== {3'b001, 5'd2})
            begin n_err++; $display("FAIL walk2_out got ren=%b fen=%b walk=%b cnt=%0d want 0/0/1/2", bus.restore_en, bus.free_en, bus.walking, bus.count); end
        tick(); #3;
        n_cmp++; if ({bus.restore_en, bus.restore_arch_rd, bus.restore_phys, bus.free_en, bus.free_reg, bus.count} !== {1'b1, 5'd1, 6'd1, 1'b1, 6'd40, 5'd1})
            begin n_err++; $display("FAIL walk3_out got ren=%b rd=%0d ph=%0d fen=%b reg=%0d cnt=%0d want 1/1/1/1/40/1", bus.restore_en, bus.restore_arch_rd, bus.restore_phys, bus.free_en, bus.free_reg, bus.count); end
        tick(); idle(); #3;
        n_cmp++; if ({bus.walking, bus.alloc_ready, bus.count, bus.alloc_idx} !== {1'b0, 1'b1, 5'd0, 4'd0})
            begin n_err++; $display("FAIL walk_done got walk=%b rdy=%b cnt=%0d idx=%0d want 0/1/0/0", bus.walking, bus.alloc_ready, bus.count, bus.alloc_idx); end
        tick();
    endtask

    task automatic test_random();
        logic a, hd, wb, fl, mapped, rst_done;
        logic [AB-1:0] rd;
        logic [PB-1:0] np, op;
        logic [IB-1:0] wi;
        int n_alloc;
        do_reset();
        model_reset();
        rst_done = 1'b0;
        n_alloc = 0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            if (cyc >= 150 && !rst_done && m_walk && mq.size() >= 2) begin
                idle(); #1;
                rst_n = 1'b0; #1;
                n_cmp++; if ({bus.count, bus.alloc_ready, bus.alloc_idx, bus.walking, bus.free_en, bus.restore_en, bus.commit_en} !== {5'd0, 1'b1, 4'd0, 4'b0})
                    begin n_err++; $display("FAIL rst_mid_walk got cnt=%0d rdy=%b idx=%0d walk=%b fen=%b ren=%b cen=%b", bus.count, bus.alloc_ready, bus.alloc_idx, bus.walking, bus.free_en, bus.restore_en, bus.commit_en); end
                model_reset();
                @(negedge clk) rst_n = 1'b1;
                @(posedge clk); #1;
                rst_done = 1'b1;
                continue;
            end
            a  = ($urandom % 10) < 7;
            hd = ($urandom % 10) < 8;
            rd = AB'($urandom);
            if (mq.size() > 0 && ($urandom % 4) != 0) begin
                wb = 1'b1; wi = mq[$urandom % mq.size()].idx;
            end else begin
                wb = 1'($urandom); wi = IB'($urandom);
            end
            fl = (($urandom % 32) == 0) || (cyc >= 150 && !rst_done && !m_walk && mq.size() >= 3);
            model_predict(fl);
            if (a && e_ready && !fl && hd && rd != 0) begin
                np = fl_q.pop_front(); in_free[np] = 1'b0;
                op = rat[rd]; rat[rd] = np;
            end else begin
                np = PB'($urandom); op = PB'($urandom);
            end
            if (a && e_ready && !fl) n_alloc++;
            set_in(a, hd, rd, np, op, wb, wi, fl);
            #3;
            n_cmp++; if ({bus.alloc_ready, bus.alloc_idx, bus.count, bus.walking} !== {e_ready, e_idx, e_count, e_walk})
                begin n_err++; $display("FAIL rnd_status c%0d got rdy=%b idx=%0d cnt=%0d walk=%b want %b/%0d/%0d/%b", cyc, bus.alloc_ready, bus.alloc_idx, bus.count, bus.walking, e_ready, e_idx, e_count, e_walk); end
            n_cmp++; if ({bus.commit_en, bus.commit_arch_rd, bus.commit_phys} !== {e_cen, e_crd, e_cph})
                begin n_err++; $display("FAIL rnd_commit c%0d got %b/%0d/%0d want %b/%0d/%0d", cyc, bus.commit_en, bus.commit_arch_rd, bus.commit_phys, e_cen, e_crd, e_cph); end
            n_cmp++; if ({bus.restore_en, bus.restore_arch_rd, bus.restore_phys} !== {e_ren, e_rrd, e_rph})
                begin n_err++; $display("FAIL rnd_restore c%0d got %b/%0d/%0d want %b/%0d/%0d", cyc, bus.restore_en, bus.restore_arch_rd, bus.restore_phys, e_ren, e_rrd, e_rph); end
            n_cmp++; if ({bus.free_en, bus.free_reg} !== {e_fen, e_freg})
                begin n_err++; $display("FAIL rnd_free c%0d got %b/%0d want %b/%0d", cyc, bus.free_en, bus.free_reg, e_fen, e_freg); end
            if (e_ren) rat[e_rrd] = e_rph;
            if (bus.free_en === 1'b1) begin
                mapped = 1'b0;
                for (int r = 0; r < 32; r++) if (rat[r] == bus.free_reg) mapped = 1'b1;
                n_cmp++; if (in_free[bus.free_reg] || mapped)
                    begin n_err++; $display("FAIL rnd_tag c%0d tag=%0d already_free=%b still_mapped=%b want 0/0", cyc, bus.free_reg, in_free[bus.free_reg], mapped); end
            end
            if (e_fen) begin in_free[e_freg] = 1'b1; fl_q.push_back(e_freg); end
            tick();
            model_update(a, hd, rd, np, op, wb, wi, fl);
        end
        n_cmp++; if (!rst_done || n_alloc < 40)
            begin n_err++; $display("FAIL rnd_coverage got rst_done=%b allocs=%0d want 1/>=40", rst_done, n_alloc); end
    endtask

    initial begin
        rst_n = 1'b0;
        idle();
        test_reset();
        test_commit();
        test_x0();
        test_full_ooo();
        test_flush_walk();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
